rtc_read_sequencer: RTL

//  Upstream bus master feeding the 11-byte capture register bank. On a start pulse, runs a burst of 11

---
 rtl/rtc_pkg.sv | 39 +++
 rtl/rtc_phase_decode.sv | 58 +++++
 rtl/rtc_read_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC read sequencer: frame timing windows,
// the RTC register address table, init-write values and the FSM state type.
package rtc_pkg;

  localparam int unsigned N_REGS = 11;

  // Frame timing, expressed as contador values.
  localparam logic [7:0] CYCLE_LAST = 8'd236;  // CYCLE_LEN (237) - 1
  localparam logic [7:0] ADDR_START = 8'd10;
  localparam logic [7:0] ADDR_END   = 8'd69;
  localparam logic [7:0] DATA_START = 8'd90;
  localparam logic [7:0] SAMPLE_PT  = 8'd150;
  localparam logic [7:0] DATA_END   = 8'd229;

  localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);

  localparam logic [7:0] INIT_ADDR = 8'h02;
  localparam logic [7:0] INIT_DATA = 8'h10;

  localparam logic [7:0] RTC_ADDR [0:10] = '{
    8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd33, 8'd34, 8'd35, 8'd240, 8'd241
  };

  typedef enum logic [1:0] {
    StIdle,
    StInitWr,
    StRun,
    StDone
  } state_e;

  // Bounded lookup so out-of-range indices read as zero rather than X.
  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    logic [7:0] a;
    a = 8'h00;
    if (idx <= LAST_IDX) a = RTC_ADDR[idx];
    return a;
  endfunction

endpackage

// File: rtl/rtc_phase_decode.sv
// Combinational decode of the frame phase (contador) and FSM state into the
// next values of the RTC bus strobes, the pad output enable and the sample strobe.
module rtc_phase_decode
  import rtc_pkg::*;
(
  input  state_e     state,
  input  logic [7:0] contador,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic       ad_oe,
  output logic       sample
);

  logic in_addr;
  logic in_data;

  // Window decode; outside both windows everything is released.
  always_comb begin
    in_addr = (contador >= ADDR_START) && (contador <= ADDR_END);
    in_data = (contador >= DATA_START) && (contador <= DATA_END);
    cs_n    = 1'b1;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    ad_n    = 1'b1;
    ad_oe   = 1'b0;
    sample  = 1'b0;
    unique case (state)
      StRun: begin
        if (in_addr) begin
          ad_n  = 1'b0;
          cs_n  = 1'b0;
          wr_n  = 1'b0;
          ad_oe = 1'b1;
        end else if (in_data) begin
          cs_n   = 1'b0;
          rd_n   = 1'b0;
          sample = (contador == SAMPLE_PT);
        end
      end
      StInitWr: begin
        if (in_addr) begin
          ad_n  = 1'b0;
          cs_n  = 1'b0;
          wr_n  = 1'b0;
          ad_oe = 1'b1;
        end else if (in_data) begin
          cs_n  = 1'b0;
          wr_n  = 1'b0;
          ad_oe = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rtc_read_sequencer.sv
// RTC read sequencer: on start, runs a burst of N_REGS multiplexed address/data
// read frames and latches each returned byte into data_vga.
// Optional feature: define RTC_INIT_WR_EN to issue one init write frame after reset.
module rtc_read_sequencer
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] contador,
  output logic       Read,
  output logic [3:0] reg_idx,
  output logic [7:0] data_vga,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

`ifdef RTC_INIT_WR_EN
  localparam state_e ResetState = StInitWr;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] data_q;
  logic       cs_n_q, rd_n_q, wr_n_q, ad_n_q, ad_oe_q;
  logic [7:0] ad_out_q, ad_out_d;

  logic dec_cs_n, dec_rd_n, dec_wr_n, dec_ad_n, dec_ad_oe, dec_sample;

  rtc_phase_decode u_decode (
    .state    (state_q),
    .contador (cnt_q),
    .cs_n     (dec_cs_n),
    .rd_n     (dec_rd_n),
    .wr_n     (dec_wr_n),
    .ad_n     (dec_ad_n),
    .ad_oe    (dec_ad_oe),
    .sample   (dec_sample)
  );

  // Next state, frame counter and transaction index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (start) begin
          state_d = StRun;
          idx_d   = 4'd0;
        end
      end
      StInitWr: begin
        if (cnt_q == CYCLE_LAST) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (cnt_q == CYCLE_LAST) begin
          cnt_d = 8'd0;
          if (idx_q == LAST_IDX) state_d = StDone;
          else                   idx_d   = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus value to drive; zero whenever the pad is released.
  always_comb begin
    ad_out_d = 8'h00;
    if (dec_ad_oe) begin
      if (state_q == StInitWr) ad_out_d = dec_ad_n ? INIT_DATA : INIT_ADDR;
      else                     ad_out_d = rtc_addr(idx_q);
    end
  end

  // State, counters, captured byte and registered bus strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ResetState;
      cnt_q    <= 8'd0;
      idx_q    <= 4'd0;
      data_q   <= 8'h00;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      if (dec_sample) data_q <= ad_in;
      cs_n_q   <= dec_cs_n;
      rd_n_q   <= dec_rd_n;
      wr_n_q   <= dec_wr_n;
      ad_n_q   <= dec_ad_n;
      ad_oe_q  <= dec_ad_oe;
      ad_out_q <= ad_out_d;
    end
  end

  assign busy     = (state_q == StRun) || (state_q == StInitWr);
  assign done     = (state_q == StDone);
  assign Read     = (state_q != StRun);
  assign contador = cnt_q;
  assign reg_idx  = idx_q;
  assign data_vga = data_q;
  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign ad_n     = ad_n_q;
  assign ad_oe    = ad_oe_q;
  assign ad_out   = ad_out_q;

endmodule
